// File: rtl/issue_queue_if.sv
// Issue-queue element type plus the decoder/execute/writeback bundle wrapped around the queue.
// The queue sits on the slave modport; whatever drives it uses the master modport.
package issue_queue_pkg;
  typedef struct packed {
    logic [7:0] tag;
    logic       num1_need;
    logic [4:0] num1_addr;
    logic       num2_need;
    logic [4:0] num2_addr;
    logic       write_reg_need;
    logic [4:0] write_reg_addr;
  } issue_queue_element_t;
endpackage

interface issue_queue_if #(parameter int DEPTH = 8);
  import issue_queue_pkg::*;
  logic                       enq_valid;
  issue_queue_element_t       enq_elem;
  logic                       enq_ready;
  logic                       deq_valid;
  issue_queue_element_t       deq_elem;
  logic                       deq_ready;
  logic                       wb_valid;
  logic [4:0]                 wb_addr;
  logic                       flush;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  enq_valid, enq_elem, deq_ready, wb_valid, wb_addr, flush,
    output enq_ready, deq_valid, deq_elem, count
  );
  modport master (
    output enq_valid, enq_elem, deq_ready, wb_valid, wb_addr, flush,
    input  enq_ready, deq_valid, deq_elem, count
  );
endinterface

// File: rtl/issue_queue.sv
// In-order issue queue with a GPR busy scoreboard. Only the head entry can issue.
// Optional macro ISSUE_QUEUE_BYPASS_EN lets an eligible element issue straight from enq when the queue is empty.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  issue_queue_if.slave  q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  issue_queue_element_t r_mem [DEPTH];
  logic [AW-1:0]        r_head, r_tail;
  logic [CW-1:0]        r_count;
  logic [31:0]          r_busy;

  logic                 w_head_ok, w_byp, w_enq_fire, w_deq_fire, w_wr, w_pop;
  issue_queue_element_t w_head;
  logic [31:0]          w_busy_nxt;

  function automatic logic f_elig(issue_queue_element_t e, logic [31:0] b);
    return (!e.num1_need || (e.num1_addr == 5'd0) || !b[e.num1_addr]) &&
           (!e.num2_need || (e.num2_addr == 5'd0) || !b[e.num2_addr]);
  endfunction

  assign w_head    = r_mem[r_head];
  assign w_head_ok = f_elig(w_head, r_busy);

`ifdef ISSUE_QUEUE_BYPASS_EN
  assign w_byp = (r_count == '0) && q_if.enq_valid && !q_if.flush && f_elig(q_if.enq_elem, r_busy);
`else
  assign w_byp = 1'b0;
`endif

  assign q_if.enq_ready = (r_count != CW'(DEPTH));
  assign q_if.deq_valid = ((r_count != '0) && w_head_ok) || w_byp;
  assign q_if.deq_elem  = w_byp ? q_if.enq_elem : w_head;
  assign q_if.count     = r_count;

  assign w_enq_fire = q_if.enq_valid && q_if.enq_ready;
  assign w_deq_fire = q_if.deq_valid && q_if.deq_ready;
  // A bypassed element that issues immediately is never written into the ring.
  assign w_wr  = w_enq_fire && !(w_byp && q_if.deq_ready);
  assign w_pop = w_deq_fire && !w_byp;

  always_comb begin
    w_busy_nxt = r_busy;
    if (q_if.wb_valid) w_busy_nxt[q_if.wb_addr] = 1'b0;
    // Set after clear so a same-cycle issue of the same register wins.
    if (w_deq_fire && !q_if.flush && q_if.deq_elem.write_reg_need &&
        (q_if.deq_elem.write_reg_addr != 5'd0))
      w_busy_nxt[q_if.deq_elem.write_reg_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (q_if.flush) begin
        r_count <= '0;
        r_head  <= r_tail;
      end else begin
        if (w_wr)  r_tail <= r_tail + 1'b1;
        if (w_pop) r_head <= r_head + 1'b1;
        r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !q_if.flush && w_wr) r_mem[r_tail] <= q_if.enq_elem;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entry count (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enq_valid  input  1  decoder presents a decoded element.
REQ-005 SHALL have port enq_elem  input  ISSUE_QUEUE_ELEMENT  decoded element from decoder.
REQ-006 SHALL have port enq_ready  output  1  queue accepts the element this cycle.
REQ-007 SHALL have port deq_valid  output  1  head element is eligible for issue.
REQ-008 SHALL have port deq_elem  output  ISSUE_QUEUE_ELEMENT  element offered to the execute stage.
REQ-009 SHALL have port deq_ready  input  1  execute stage takes deq_elem.
REQ-010 SHALL have port wb_valid  input  1  a register writeback completes.
REQ-011 SHALL have port wb_addr  input  5  register written back.
REQ-012 SHALL have port flush  input  1  mispredict/redirect, discard all queued elements.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL store elements in-order in a circular buffer with head/tail pointers wrapping modulo DEPTH; enqueue fires on enq_valid&&enq_ready, dequeue on deq_valid&&deq_ready.
REQ-015 SHALL drive enq_ready = (count != DEPTH); simultaneous dequeue does not raise enq_ready in the same cycle.
REQ-016 SHALL keep a 32-bit busy scoreboard, one bit per GPR; register 0 is never busy.
REQ-017 SHALL treat the head as eligible when, for each of num1/num2, num*_need is false, or num*_addr is 0, or busy[num*_addr] is 0, using the registered busy value (no same-cycle wb bypass).
REQ-018 SHALL drive deq_valid = (count != 0) && head eligible, with deq_elem = head entry; deq_elem is don't-care when deq_valid is 0.
REQ-019 SHALL hold deq_elem stable while deq_valid && !deq_ready and no flush.
REQ-020 SHALL, on dequeue of an element with write_reg_need and write_reg_addr != 0, set busy[write_reg_addr] at the next edge.
REQ-021 SHALL, on wb_valid, clear busy[wb_addr] at the next edge; if the same register is set by a dequeue in the same cycle, set wins.
REQ-022 SHALL, on flush, set count to 0 and head=tail at the next edge, ignore enq/deq fire that cycle, and keep busy bits unchanged (in-flight ops still write back); wb_valid is still applied.
REQ-023 SHALL, with simultaneous enqueue and dequeue, leave count unchanged.
REQ-024 SHALL never issue out of order; an ineligible head blocks all younger entries.

Reset
REQ-025 SHALL, on rst at the clock edge, set head=tail=0, count=0, busy=0; outputs then read enq_ready=1, deq_valid=0.
REQ-026 SHALL give rst priority over flush, enqueue, dequeue and writeback in the same cycle, including mid-operation with a full queue.

Configuration
REQ-027 SHALL support macro ISSUE_QUEUE_BYPASS_EN; when defined, if count==0, enq_valid=1, no flush and enq_elem is eligible per REQ-017, deq_valid=1 and deq_elem=enq_elem combinationally, and if deq_ready=1 the element is issued without being written (count stays 0, REQ-020 applies).
REQ-028 SHALL, without ISSUE_QUEUE_BYPASS_EN, give an element entering an empty queue a minimum latency of one cycle from enqueue to deq_valid.

Verification
REQ-029 SHALL cover: reset, enqueue 8 ADDIU with deq_ready=0 -> count=8, enq_ready=0; 9th enq_valid not accepted; then deq_ready=1 -> 8 issues in program order.
REQ-030 SHALL cover: issue ADDIU rt=5, next ADDU rs=5 -> ADDU deq_valid=0 until wb_valid with wb_addr=5, deq_valid=1 exactly one cycle after the wb edge.
REQ-031 SHALL cover: same cycle dequeue LW rt=7 and wb_valid wb_addr=7 -> busy[7]=1 afterwards.
REQ-032 SHALL cover: queue holding 5 entries, flush=1 with enq_valid=1 -> count=0 next cycle, enqueued element dropped, busy unchanged.
REQ-033 SHALL cover: LUI rt=0 and ORI rs=0 -> no busy set, no stall on register 0.
REQ-034 SHALL cover: with ISSUE_QUEUE_BYPASS_EN, empty queue, eligible enq with deq_ready=1 -> deq_valid same cycle, count stays 0; without macro -> deq_valid one cycle later.
